// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - scoreboard-based stall, forward and flush control for the 5-stage core
module hazard_controller #(
    parameter int REGISTER_SIZE = 5,
    parameter int FLUSH_CYCLES  = 1,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_valid,
    input  logic [REGISTER_SIZE-1:0] dec_rs1_addr,
    input  logic [REGISTER_SIZE-1:0] dec_rs2_addr,
    input  logic                     dec_rs1_used,
    input  logic                     dec_rs2_used,
    input  logic [REGISTER_SIZE-1:0] dec_rd_addr,
    input  logic                     dec_rd_we,
    input  logic                     dec_is_load,
    input  logic                     dec_is_jump,
    input  logic                     dbg_wr_en,
    output logic                     f_to_d_enable,
    output logic                     d_to_e_enable,
    output logic                     bubble,
    output logic                     flush_decode,
    output logic [1:0][1:0]          pipeline_forward_sel,
    output logic [CNT_WIDTH-1:0]     stall_count,
    output logic [CNT_WIDTH-1:0]     flush_count
);
    typedef enum logic [1:0] {RUN, STALL, FLUSH, HALT} state_t;

    typedef struct packed {
        logic                     valid;
        logic [REGISTER_SIZE-1:0] rd;
        logic                     we;
        logic                     is_load;
    } sb_entry_t;

    localparam logic [1:0] FLUSH_INIT  = 2'(FLUSH_CYCLES);
    localparam logic [1:0] FWD_RF      = 2'd0;
    localparam logic [1:0] FWD_MEM_DM  = 2'd1;
    localparam logic [1:0] FWD_EX_ALU  = 2'd2;
    localparam logic [1:0] FWD_MEM_ALU = 2'd3;

    state_t     state, cur_state, next_state;
    logic [1:0] flush_cnt, next_flush_cnt;
    sb_entry_t  ex_entry, mem_entry;
    logic       ex_rs1, ex_rs2, mem_rs1, mem_rs2, load_use;
    logic [1:0] fwd_a, fwd_b;

    function automatic logic sb_match(input sb_entry_t e,
                                      input logic [REGISTER_SIZE-1:0] rs,
                                      input logic used);
        return e.valid && e.we && (e.rd == rs) && (rs != '0) && used;
    endfunction

    function automatic logic [1:0] fwd_select(input logic ex_hit, input logic ex_load,
                                              input logic mem_hit, input logic mem_load);
        if (ex_hit && !ex_load)
            return FWD_EX_ALU;
        else if (mem_hit && mem_load)
            return FWD_MEM_DM;
        else if (mem_hit)
            return FWD_MEM_ALU;
        else
            return FWD_RF;
    endfunction

    assign ex_rs1   = sb_match(ex_entry, dec_rs1_addr, dec_rs1_used);
    assign ex_rs2   = sb_match(ex_entry, dec_rs2_addr, dec_rs2_used);
    assign mem_rs1  = sb_match(mem_entry, dec_rs1_addr, dec_rs1_used);
    assign mem_rs2  = sb_match(mem_entry, dec_rs2_addr, dec_rs2_used);
    assign load_use = ex_entry.is_load && (ex_rs1 || ex_rs2);
    assign fwd_a    = fwd_select(ex_rs1, ex_entry.is_load, mem_rs1, mem_entry.is_load);
    assign fwd_b    = fwd_select(ex_rs2, ex_entry.is_load, mem_rs2, mem_entry.is_load);

    // STALL is taken in the very cycle the hazard is seen, so the dependent
    // instruction never leaves DECODE with a stale operand.
    always_comb begin
        cur_state            = (state == RUN && load_use) ? STALL : state;
        next_state           = state;
        next_flush_cnt       = flush_cnt;
        f_to_d_enable        = 1'b1;
        d_to_e_enable        = 1'b1;
        bubble               = 1'b0;
        flush_decode         = 1'b0;
        pipeline_forward_sel = {fwd_b, fwd_a};
        case (cur_state)
            RUN: begin
                if (dec_is_jump && dec_valid) begin
                    next_state     = FLUSH;
                    next_flush_cnt = FLUSH_INIT;
                end
            end
            STALL: begin
                f_to_d_enable        = 1'b0;
                bubble               = 1'b1;
                pipeline_forward_sel = '0;
                next_state           = RUN;
            end
            FLUSH: begin
                flush_decode = 1'b1;
                if (flush_cnt <= 2'd1)
                    next_state = RUN;
                else
                    next_flush_cnt = flush_cnt - 2'd1;
            end
            HALT: begin
                f_to_d_enable = 1'b0;
                d_to_e_enable = 1'b0;
                bubble        = 1'b1;
                if (!dbg_wr_en) begin
                    next_state     = FLUSH;
                    next_flush_cnt = FLUSH_INIT;
                end
            end
            default: next_state = RUN;
        endcase
        if (dbg_wr_en)
            next_state = HALT;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= next_state;
            flush_cnt <= next_flush_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_entry  <= '0;
            mem_entry <= '0;
        end else begin
            mem_entry <= ex_entry;
            if (d_to_e_enable && !bubble && dec_valid)
                ex_entry <= {1'b1, dec_rd_addr, dec_rd_we, dec_is_load};
            else
                ex_entry <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            if (cur_state == STALL && stall_count != '1)
                stall_count <= stall_count + CNT_WIDTH'(1);
            if (flush_decode && flush_count != '1)
                flush_count <= flush_count + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - scoreboard bench for hazard_controller with directed instruction vectors
module tb_hazard_controller;
    localparam int RS = 5;
    localparam int FC = 2;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          dec_valid = 1'b0;
    logic [RS-1:0] dec_rs1_addr = '0;
    logic [RS-1:0] dec_rs2_addr = '0;
    logic          dec_rs1_used = 1'b0;
    logic          dec_rs2_used = 1'b0;
    logic [RS-1:0] dec_rd_addr = '0;
    logic          dec_rd_we = 1'b0;
    logic          dec_is_load = 1'b0;
    logic          dec_is_jump = 1'b0;
    logic          dbg_wr_en = 1'b0;
    logic          f_to_d_enable, d_to_e_enable, bubble, flush_decode;
    logic [1:0][1:0] pipeline_forward_sel;
    logic [CW-1:0] stall_count, flush_count;

    hazard_controller #(.REGISTER_SIZE(RS), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid),
        .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .dec_rd_addr(dec_rd_addr), .dec_rd_we(dec_rd_we),
        .dec_is_load(dec_is_load), .dec_is_jump(dec_is_jump),
        .dbg_wr_en(dbg_wr_en),
        .f_to_d_enable(f_to_d_enable), .d_to_e_enable(d_to_e_enable),
        .bubble(bubble), .flush_decode(flush_decode),
        .pipeline_forward_sel(pipeline_forward_sel),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       fte, dte, bub, fl;
        logic [1:0] s0, s1;
        int         sc, fc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   compared = 0;
    int   mismatched = 0;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            compared++;
            if ({f_to_d_enable, d_to_e_enable, bubble, flush_decode,
                 pipeline_forward_sel[0], pipeline_forward_sel[1]} !==
                {mon_e.fte, mon_e.dte, mon_e.bub, mon_e.fl, mon_e.s0, mon_e.s1}) begin
                mismatched++;
                $display("FAIL %s: got fte=%b dte=%b bub=%b fl=%b sel0=%0d sel1=%0d, want fte=%b dte=%b bub=%b fl=%b sel0=%0d sel1=%0d",
                         mon_e.name, f_to_d_enable, d_to_e_enable, bubble, flush_decode,
                         pipeline_forward_sel[0], pipeline_forward_sel[1],
                         mon_e.fte, mon_e.dte, mon_e.bub, mon_e.fl, mon_e.s0, mon_e.s1);
            end
            if (mon_e.sc >= 0) begin
                compared++;
                if (stall_count !== CW'(mon_e.sc) || flush_count !== CW'(mon_e.fc)) begin
                    mismatched++;
                    $display("FAIL %s_counts: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
                             mon_e.name, stall_count, flush_count, mon_e.sc, mon_e.fc);
                end
            end
        end
    end

    task automatic set_instr(input logic [RS-1:0] rs1, input logic u1,
                             input logic [RS-1:0] rs2, input logic u2,
                             input logic [RS-1:0] rd, input logic we,
                             input logic ld, input logic jmp);
        dec_valid    = 1'b1;
        dec_rs1_addr = rs1;
        dec_rs1_used = u1;
        dec_rs2_addr = rs2;
        dec_rs2_used = u2;
        dec_rd_addr  = rd;
        dec_rd_we    = we;
        dec_is_load  = ld;
        dec_is_jump  = jmp;
    endtask

    task automatic set_nop();
        set_instr('0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        dec_valid = 1'b0;
    endtask

    // Queue the response expected for the inputs just driven, then advance one clock.
    task automatic cyc(input string name, input logic fte, input logic dte,
                       input logic bub, input logic fl,
                       input logic [1:0] s0, input logic [1:0] s1,
                       input int sc, input int fc);
        exp_t e;
        e.name = name;
        e.fte  = fte;
        e.dte  = dte;
        e.bub  = bub;
        e.fl   = fl;
        e.s0   = s0;
        e.s1   = s1;
        e.sc   = sc;
        e.fc   = fc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        set_nop();
        for (int i = 0; i < n; i++)
            cyc("idle", 1, 1, 0, 0, 0, 0, -1, -1);
    endtask

    initial begin
        @(posedge clk);
        #1;
        cyc("reset", 1, 1, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;

        set_instr(1, 1, 2, 1, 5, 1, 0, 0); cyc("add_x5", 1, 1, 0, 0, 0, 0, -1, -1);
        set_instr(5, 1, 5, 1, 6, 1, 0, 0); cyc("add_x6_fwd_ex", 1, 1, 0, 0, 2, 2, -1, -1);
        idle(2);

        set_instr(1, 1, 0, 0, 5, 1, 1, 0); cyc("lw_x5", 1, 1, 0, 0, 0, 0, -1, -1);
        set_instr(5, 1, 1, 1, 7, 1, 0, 0); cyc("load_use_stall", 0, 1, 1, 0, 0, 0, 0, 0);
        cyc("after_stall_fwd_dm", 1, 1, 0, 0, 1, 0, 1, 0);
        idle(2);

        set_instr(1, 1, 2, 1, 5, 1, 0, 0); cyc("add_x5_b", 1, 1, 0, 0, 0, 0, -1, -1);
        set_nop();                         cyc("gap_nop", 1, 1, 0, 0, 0, 0, -1, -1);
        set_instr(2, 1, 5, 1, 0, 0, 0, 0); cyc("sw_fwd_mem_alu", 1, 1, 0, 0, 0, 3, -1, -1);
        idle(2);

        set_instr(1, 1, 2, 1, 0, 1, 0, 0); cyc("add_x0", 1, 1, 0, 0, 0, 0, -1, -1);
        set_instr(0, 1, 0, 1, 3, 1, 0, 0); cyc("x0_in_ex", 1, 1, 0, 0, 0, 0, -1, -1);
        set_instr(0, 1, 0, 1, 4, 1, 0, 0); cyc("x0_in_mem", 1, 1, 0, 0, 0, 0, -1, -1);
        idle(2);

        set_instr(1, 1, 0, 0, 5, 1, 1, 0); cyc("lw_x5_b", 1, 1, 0, 0, 0, 0, -1, -1);
        set_instr(1, 1, 2, 1, 5, 1, 0, 0); cyc("add_x5_over_lw", 1, 1, 0, 0, 0, 0, -1, -1);
        set_instr(5, 1, 0, 0, 8, 1, 0, 0); cyc("ex_beats_mem", 1, 1, 0, 0, 2, 0, -1, -1);
        idle(2);

        set_instr(0, 0, 0, 0, 1, 1, 0, 1); cyc("jal", 1, 1, 0, 0, 0, 0, 1, 0);
        set_instr(0, 0, 0, 0, 0, 0, 0, 1); cyc("jump_in_flush_ignored", 1, 1, 0, 1, 0, 0, -1, -1);
        set_nop();                         cyc("jal_flush2", 1, 1, 0, 1, 0, 0, -1, -1);
        cyc("after_jal", 1, 1, 0, 0, 0, 0, 1, 2);
        idle(1);

        set_instr(2, 1, 0, 0, 1, 1, 1, 0); cyc("lw_x1", 1, 1, 0, 0, 0, 0, -1, -1);
        set_instr(1, 1, 0, 0, 0, 1, 0, 1); cyc("jalr_stall", 0, 1, 1, 0, 0, 0, -1, -1);
        cyc("jalr_taken", 1, 1, 0, 0, 1, 0, 2, 2);
        set_nop();                         cyc("jalr_flush1", 1, 1, 0, 1, 0, 0, -1, -1);
        cyc("jalr_flush2", 1, 1, 0, 1, 0, 0, -1, -1);
        cyc("after_jalr", 1, 1, 0, 0, 0, 0, 2, 4);

        dbg_wr_en = 1'b1;
        set_instr(1, 1, 2, 1, 9, 1, 0, 0);  cyc("dbg_first", 1, 1, 0, 0, 0, 0, -1, -1);
        set_instr(9, 1, 9, 1, 10, 1, 0, 0); cyc("halt1_fwd_ex", 0, 0, 1, 0, 2, 2, -1, -1);
        cyc("halt2_fwd_mem", 0, 0, 1, 0, 3, 3, -1, -1);
        dbg_wr_en = 1'b0;
        cyc("halt3_drained", 0, 0, 1, 0, 0, 0, -1, -1);
        set_nop();                          cyc("halt_flush1", 1, 1, 0, 1, 0, 0, -1, -1);
        cyc("halt_flush2", 1, 1, 0, 1, 0, 0, -1, -1);
        cyc("after_halt", 1, 1, 0, 0, 0, 0, 2, 6);

        set_instr(0, 0, 0, 0, 0, 0, 0, 1); cyc("jal_again", 1, 1, 0, 0, 0, 0, -1, -1);
        set_nop();                         cyc("jal_again_flush1", 1, 1, 0, 1, 0, 0, -1, -1);
        rst = 1'b0;
        cyc("reset_mid_flush", 1, 1, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        cyc("after_reset_run", 1, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        if (exp_q.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
